// File: rtl/led_pkg.sv
// Shared definitions for the running-light LED generator/checker pair.
// Holds FSM encoding, error-cause codes and the S2 board defaults.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_ONEHOT = 2'd1;
  localparam logic [1:0] ERR_ORDER  = 2'd2;
  localparam logic [1:0] ERR_PERIOD = 2'd3;

  localparam int unsigned LED_W_DEF    = 4;
  localparam int unsigned STEP_CNT_DEF = 25_000_000;
  localparam int unsigned TOL_DEF      = 1;

  localparam int unsigned LAP_W  = 16;
  localparam int unsigned GOOD_W = 2;

  // Consecutive good steps needed in ACQUIRE before declaring lock.
  localparam logic [GOOD_W-1:0] GOOD_LOCK = 2'd2;

endpackage

// File: rtl/led_step_check.sv
// Combinational judgement of one LED step: one-hot, rotate-by-one and period window.
// Cause is prioritised one-hot > order > period; good means no cause.
module led_step_check
  import led_pkg::*;
#(
  parameter int unsigned LED_W    = LED_W_DEF,
  parameter int unsigned STEP_CNT = STEP_CNT_DEF,
  parameter int unsigned TOL      = TOL_DEF,
  parameter int unsigned CNT_W    = $clog2(STEP_CNT + TOL + 2)
) (
  input  logic [LED_W-1:0] led_in,
  input  logic [LED_W-1:0] led_prev,
  input  logic [CNT_W:0]   interval,
  input  logic             check_period,
  output logic             good,
  output logic [1:0]       cause
);

  localparam int unsigned WIN_LO = STEP_CNT - TOL;
  localparam int unsigned WIN_HI = STEP_CNT + TOL;

  logic             one_hot;
  logic             in_order;
  logic             in_window;
  logic [LED_W-1:0] expect_led;

  always_comb begin
    // Wrap from MSB back to bit 0.
    expect_led = {led_prev[LED_W-2:0], led_prev[LED_W-1]};
    one_hot    = (led_in != '0) && ((led_in & (led_in - LED_W'(1))) == '0);
    in_order   = (led_in == expect_led);
    in_window  = (interval >= (CNT_W+1)'(WIN_LO)) && (interval <= (CNT_W+1)'(WIN_HI));

    cause = ERR_NONE;
    if (!one_hot) begin
      cause = ERR_ONEHOT;
    end else if (!in_order) begin
      cause = ERR_ORDER;
    end else if (check_period && !in_window) begin
      cause = ERR_PERIOD;
    end
    good = (cause == ERR_NONE);
  end

endmodule

// File: rtl/led_flow_checker.sv
// Receive-side monitor for the running-light LED pattern: tracks lock, flags
// sticky errors, measures step period and counts completed laps.
module led_flow_checker
  import led_pkg::*;
#(
  parameter int unsigned  LED_W    = LED_W_DEF,
  parameter int unsigned  STEP_CNT = STEP_CNT_DEF,
  parameter int unsigned  TOL      = TOL_DEF,
  localparam int unsigned CNT_W    = $clog2(STEP_CNT + TOL + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic [LED_W-1:0] led_in,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] step_period,
  output logic [LAP_W-1:0] lap_cnt
);

  localparam int unsigned STALL_LIM = STEP_CNT + TOL;

  state_t            state;
  state_t            state_nx;
  logic [LED_W-1:0]  led_q;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  per_nx;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nx;
  logic              first_pend;
  logic              first_nx;
  logic [1:0]        code_nx;
  logic [CNT_W-1:0]  period_nx;
  logic [LAP_W-1:0]  lap_nx;

  logic              change;
  logic              stall;
  logic              check_period;
  logic              step_good;
  logic [1:0]        step_cause;
  logic [CNT_W:0]    interval;
  logic [CNT_W-1:0]  interval_sat;

  // Interval is one wider than per_cnt so the saturated count cannot wrap.
  always_comb begin
    change       = (led_in != led_q);
    interval     = {1'b0, per_cnt} + (CNT_W+1)'(1);
    interval_sat = interval[CNT_W] ? '1 : interval[CNT_W-1:0];
    stall        = !change && (interval > (CNT_W+1)'(STALL_LIM));
    check_period = !((state == ST_ACQUIRE) && first_pend);
  end

  led_step_check #(
    .LED_W    (LED_W),
    .STEP_CNT (STEP_CNT),
    .TOL      (TOL),
    .CNT_W    (CNT_W)
  ) u_step_check (
    .led_in       (led_in),
    .led_prev     (led_q),
    .interval     (interval),
    .check_period (check_period),
    .good         (step_good),
    .cause        (step_cause)
  );

  // Next-state and next-register values.
  always_comb begin
    state_nx  = state;
    per_nx    = change ? '0 : ((&per_cnt) ? per_cnt : per_cnt + CNT_W'(1));
    good_nx   = good_cnt;
    first_nx  = first_pend;
    code_nx   = err_code;
    period_nx = step_period;
    lap_nx    = lap_cnt;

    if (!enable) begin
      state_nx = ST_IDLE;
      per_nx   = '0;
      good_nx  = '0;
      lap_nx   = '0;
      code_nx  = ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_ACQUIRE;
          per_nx   = '0;
          good_nx  = '0;
          first_nx = 1'b1;
          lap_nx   = '0;
          code_nx  = ERR_NONE;
        end
        ST_ACQUIRE: begin
          if (change) begin
            period_nx = interval_sat;
            first_nx  = 1'b0;
            if (step_good) begin
              good_nx = good_cnt + GOOD_W'(1);
              if (good_nx == GOOD_LOCK) begin
                state_nx = ST_TRACK;
              end
            end else begin
              good_nx = '0;
            end
          end else if (stall) begin
            good_nx = '0;
          end
        end
        ST_TRACK: begin
          if (change) begin
            period_nx = interval_sat;
            if (!step_good) begin
              state_nx = ST_ERROR;
              code_nx  = step_cause;
            end else if ((led_in == LED_W'(1)) && (lap_cnt != '1)) begin
              lap_nx = lap_cnt + LAP_W'(1);
            end
          end else if (stall) begin
            state_nx = ST_ERROR;
            code_nx  = ERR_PERIOD;
          end
        end
        ST_ERROR: begin
          if (clr) begin
            state_nx = ST_ACQUIRE;
            per_nx   = '0;
            good_nx  = '0;
            first_nx = 1'b1;
            code_nx  = ERR_NONE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      led_q       <= '0;
      per_cnt     <= '0;
      good_cnt    <= '0;
      first_pend  <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      step_period <= '0;
      lap_cnt     <= '0;
    end else begin
      state       <= state_nx;
      led_q       <= led_in;
      per_cnt     <= per_nx;
      good_cnt    <= good_nx;
      first_pend  <= first_nx;
      locked      <= (state_nx == ST_TRACK);
      err         <= (state_nx == ST_ERROR);
      err_code    <= code_nx;
      step_period <= period_nx;
      lap_cnt     <= lap_nx;
    end
  end

endmodule

// File: tb/tb_led_flow_checker.sv
// Bench for led_flow_checker: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the step rules.
module tb_led_flow_checker;

  localparam int STEP   = 10;
  localparam int TOL    = 1;
  localparam int WIN_LO = STEP - TOL;
  localparam int WIN_HI = STEP + TOL;
  localparam int SP_MAX = 15;
  localparam int LAP_MAX = 65535;

  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_TRACK = 2;
  localparam int M_ERR   = 3;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clr;
  logic [3:0]  led_in;
  logic        locked;
  logic        err;
  logic [1:0]  err_code;
  logic [3:0]  step_period;
  logic [15:0] lap_cnt;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;
  bit lap_override = 1'b0;
  logic [3:0] cur = 4'd0;

  int m_mode = M_IDLE;
  int m_prev = 0;
  int m_code = 0;
  int m_sp   = 0;
  int m_lap  = 0;
  int m_good = 0;
  int m_mark = 0;
  int m_cyc  = 0;
  bit m_first = 1'b0;

  int bad_iv[4] = '{7, 8, 12, 13};

  led_flow_checker #(
    .LED_W    (4),
    .STEP_CNT (STEP),
    .TOL      (TOL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clr         (clr),
    .led_in      (led_in),
    .locked      (locked),
    .err         (err),
    .err_code    (err_code),
    .step_period (step_period),
    .lap_cnt     (lap_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rotl4(input int v);
    return ((v << 1) | (v >> 3)) & 15;
  endfunction

  // Cause of a step from the rules: 1 not one-hot, 2 wrong order, 3 bad period.
  function automatic int classify(input int v, input int p, input int diff, input bit per);
    if ($countones(v) != 1) return 1;
    if (v != rotl4(p)) return 2;
    if (per && (diff < WIN_LO || diff > WIN_HI)) return 3;
    return 0;
  endfunction

  // Reference model: steps measured as edge-index differences since last mark.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_prev = 0; m_code = 0; m_sp = 0; m_lap = 0;
      m_good = 0; m_mark = 0; m_cyc = 0; m_first = 1'b0;
    end else begin
      int  v;
      int  diff;
      int  cause;
      bit  chg;
      v    = int'(led_in);
      chg  = (v != m_prev);
      diff = m_cyc - m_mark;
      if (lap_override) m_lap = LAP_MAX;
      if (!enable) begin
        m_mode = M_IDLE; m_lap = 0; m_code = 0; m_good = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            m_mode = M_ACQ; m_mark = m_cyc; m_good = 0; m_first = 1'b1;
          end
          M_ACQ: begin
            if (chg) begin
              cause   = classify(v, m_prev, diff, !m_first);
              m_sp    = (diff > SP_MAX) ? SP_MAX : diff;
              m_mark  = m_cyc;
              m_first = 1'b0;
              if (cause == 0) begin
                m_good++;
                if (m_good == 2) m_mode = M_TRACK;
              end else begin
                m_good = 0;
              end
            end else if (diff > WIN_HI) begin
              m_good = 0;
            end
          end
          M_TRACK: begin
            if (chg) begin
              cause  = classify(v, m_prev, diff, 1'b1);
              m_sp   = (diff > SP_MAX) ? SP_MAX : diff;
              m_mark = m_cyc;
              if (cause != 0) begin
                m_mode = M_ERR; m_code = cause;
              end else if (v == 1 && m_lap < LAP_MAX) begin
                m_lap++;
              end
            end else if (diff > WIN_HI) begin
              m_mode = M_ERR; m_code = 3;
            end
          end
          default: begin
            if (clr) begin
              m_mode = M_ACQ; m_mark = m_cyc; m_good = 0; m_first = 1'b1; m_code = 0;
            end
          end
        endcase
      end
      m_prev = v;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      chk("locked", int'(locked), int'(m_mode == M_TRACK));
      chk("err", int'(err), int'(m_mode == M_ERR));
      chk("err_code", int'(err_code), m_code);
      chk("step_period", int'(step_period), m_sp);
      chk("lap_cnt", int'(lap_cnt), m_lap);
    end
  end

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic step(input logic [3:0] v, input int n);
    led_in = v;
    cur    = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic lock_up();
    if ($countones(cur) != 1) step(4'b0001, STEP);
    step(rot(cur), STEP);
    step(rot(cur), STEP);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_code"}, int'(err_code), 0);
    chk({tag, "_period"}, int'(step_period), 0);
    chk({tag, "_lap"}, int'(lap_cnt), 0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; led_in = 4'd0; cur = 4'd0;
    #35;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Ideal generator: lock after two good steps, laps on return to bit 0.
    enable = 1'b1;
    step(4'b0001, STEP);
    step(4'b0010, STEP);
    step(4'b0100, 1);
    chk("lock_after_2_good", int'(locked), 1);
    chk("period_ideal", int'(step_period), 10);
    hold(STEP - 1);
    step(4'b1000, STEP);
    step(4'b0001, 1);
    chk("lap_first", int'(lap_cnt), 1);
    hold(STEP - 1);
    step(4'b0010, STEP); step(4'b0100, STEP); step(4'b1000, STEP);
    step(4'b0001, 1);
    chk("lap_second", int'(lap_cnt), 2);
    hold(STEP - 1);

    // Wrong order while locked, held, then cleared.
    step(4'b0010, STEP);
    step(4'b1000, 1);
    chk("order_err", int'(err), 1);
    chk("order_code", int'(err_code), 2);
    chk("order_unlocked", int'(locked), 0);
    hold(30);
    chk("order_code_held", int'(err_code), 2);
    pulse_clr();
    chk("clr_err", int'(err), 0);
    chk("clr_code", int'(err_code), 0);

    // Late step (13 cycles) then a frozen bus.
    lock_up();
    step(4'b0100, 13);
    step(4'b1000, 1);
    chk("late_code", int'(err_code), 3);
    pulse_clr();
    lock_up();
    step(4'b0100, 12);
    chk("stall_not_yet", int'(err), 0);
    hold(1);
    chk("stall_err", int'(err), 1);
    chk("stall_code", int'(err_code), 3);
    pulse_clr();

    // Non one-hot patterns, including all-zero.
    lock_up();
    step(4'b0110, 1);
    chk("twohot_code", int'(err_code), 1);
    pulse_clr();
    lock_up();
    step(4'b0000, 1);
    chk("zero_code", int'(err_code), 1);
    pulse_clr();

    // Edge-of-window intervals, then enable drop and restart.
    lock_up();
    step(4'b1000, 9);
    step(4'b0001, 11);
    step(4'b0010, 10);
    step(4'b0100, 1);
    chk("window_no_err", int'(err), 0);
    chk("window_locked", int'(locked), 1);
    chk("window_lap", int'(lap_cnt), 3);
    hold(5);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_unlocked", int'(locked), 0);
    chk("disable_lap", int'(lap_cnt), 0);
    enable = 1'b1;
    hold(1);
    lock_up();
    step(4'b0010, STEP); step(4'b0100, STEP); step(4'b1000, STEP);
    step(4'b0001, 1);
    chk("restart_lap", int'(lap_cnt), 1);
    hold(STEP - 1);

    // Lap counter saturation.
    check_en = 1'b0;
    force dut.lap_cnt = 16'hFFFF;
    lap_override = 1'b1;
    @(negedge clk);
    release dut.lap_cnt;
    lap_override = 1'b0;
    check_en = 1'b1;
    step(4'b0010, STEP); step(4'b0100, STEP); step(4'b1000, STEP);
    step(4'b0001, 1);
    chk("lap_saturate", int'(lap_cnt), 65535);
    hold(STEP - 1);

    // Asynchronous reset between edges while in ERROR.
    step(4'b0010, STEP);
    step(4'b1000, 1);
    chk("pre_reset_err", int'(err), 1);
    hold(3);
    #5 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    hold(1);
    lock_up();
    chk("relock_after_reset", int'(locked), 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        step(($countones(cur) == 1) ? rot(cur) : 4'b0001, $urandom_range(WIN_LO, WIN_HI));
      end else if (r < 73) begin
        step(rot(cur), bad_iv[$urandom_range(0, 3)]);
      end else if (r < 78) begin
        step(rot(rot(cur)), STEP);
      end else if (r < 82) begin
        step(4'($urandom_range(0, 15)), STEP);
      end else if (r < 86) begin
        hold($urandom_range(12, 20));
      end else if (r < 94) begin
        pulse_clr();
      end else begin
        enable = 1'b0;
        hold($urandom_range(1, 3));
        enable = 1'b1;
      end
    end
    hold(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
